// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the LCD bus responder: control-bit positions,
// status-byte layout and the queued write-entry type.
package lcd_bus_pkg;

  localparam int unsigned CTRL_CE   = 0;
  localparam int unsigned CTRL_IORN = 1;
  localparam int unsigned CTRL_IOWN = 2;
  localparam int unsigned CTRL_CD   = 3;

  // Idle bus: CE, IORn, IOWn deasserted (high), CD low.
  localparam logic [3:0] CTRL_IDLE = 4'b0111;

  localparam int unsigned STAT_NOT_FULL = 0;
  localparam int unsigned STAT_EMPTY    = 1;
  localparam int unsigned STAT_OVF      = 2;
  localparam int unsigned STAT_FRESH    = 3;

  typedef struct packed {
    logic       cd;
    logic [7:0] data;
  } lcd_entry_t;

  function automatic logic [7:0] status_byte(input logic not_full,
                                             input logic empty,
                                             input logic ovf,
                                             input logic fresh);
    logic [7:0] st;
    st                = '0;
    st[STAT_NOT_FULL] = not_full;
    st[STAT_EMPTY]    = empty;
    st[STAT_OVF]      = ovf;
    st[STAT_FRESH]    = fresh;
    return st;
  endfunction

endpackage

// File: rtl/lcd_resp_fifo.sv
// Synchronous write-entry FIFO with a registered head; push and pop may
// happen in the same cycle, and a pop frees room for a push into a full FIFO.
module lcd_resp_fifo
  import lcd_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  lcd_entry_t wdata_i,
  input  logic       pop_i,
  output lcd_entry_t head_o,
  output logic       valid_o,
  output logic       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  lcd_entry_t    mem_q [DEPTH];
  lcd_entry_t    head_q, head_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != FULL_CNT) || pop_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    head_d   = head_q;
    // The new head is either already stored or is the entry arriving now.
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/lcd_bus_responder.sv
// Target-side 8080-style LCD bus endpoint: queues write cycles, answers reads.
// LCD_RESP_STATUS_EN: CD=1 reads return the status byte with overflow clear-on-read.
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       csi_clockreset_clk,
  input  logic       csi_clockreset_reset_n,
  input  logic [3:0] lcd_ctrl_in,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       cmd_valid,
  output logic       cmd_cd,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready,
  input  logic       rdata_load,
  input  logic [7:0] rdata_value,
  output logic       overflow
);

  logic                   clk, rst_n;
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;
  logic [2:0]             dly_q;
  logic [3:0]             s;
  logic                   armed_q, armed_d;
  logic                   bus_err_q, bus_err_d;
  logic                   err_now;
  logic [7:0]             data_shadow_q;
  logic                   cd_shadow_q;
  logic                   push_q, push_d;
  logic                   rd_evt_q, rd_evt_d;
  logic                   oe_q, oe_d;
  logic [7:0]             dout_q, dout_d;
  logic [7:0]             rb_q;
  logic                   ovf_q, ovf_d;
  logic                   drop;
  logic                   fifo_full;
  lcd_entry_t             head;
`ifdef LCD_RESP_STATUS_EN
  logic                   rd_cd_q;
  logic                   fresh_q, fresh_d;
  logic                   ovf_clr_q;
`endif

  assign clk   = csi_clockreset_clk;
  assign rst_n = csi_clockreset_reset_n;
  assign s     = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= CTRL_IDLE;
      end
      dly_q <= CTRL_IDLE[2:0];
      vld_q <= '0;
    end else begin
      sync_q[0] <= lcd_ctrl_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      dly_q <= s[2:0];
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Events are qualified by armed_q so that a strobe already active when reset
  // is released (seen as an edge from the reset value) is ignored until idle.
  always_comb begin
    err_now   = bus_err_q | (!s[CTRL_IOWN] & !s[CTRL_IORN]);
    bus_err_d = bus_err_q;
    if (!s[CTRL_IOWN] && !s[CTRL_IORN]) begin
      bus_err_d = 1'b1;
    end else if (s[CTRL_IOWN] && s[CTRL_IORN]) begin
      bus_err_d = 1'b0;
    end
    armed_d  = armed_q | (vld_q[SYNC_STAGES-1] & s[CTRL_IOWN] & s[CTRL_IORN]);
    push_d   = armed_q & !dly_q[CTRL_IOWN] & s[CTRL_IOWN]
             & !dly_q[CTRL_CE] & !bus_err_q;
    rd_evt_d = armed_q & dly_q[CTRL_IORN] & !s[CTRL_IORN]
             & !s[CTRL_CE] & !err_now;
    oe_d     = armed_q & !dly_q[CTRL_CE] & !dly_q[CTRL_IORN]
             & dly_q[CTRL_IOWN] & !bus_err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q       <= 1'b0;
      bus_err_q     <= 1'b0;
      data_shadow_q <= '0;
      cd_shadow_q   <= 1'b0;
      push_q        <= 1'b0;
      rd_evt_q      <= 1'b0;
      oe_q          <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      bus_err_q <= bus_err_d;
      if (!s[CTRL_IOWN] && !s[CTRL_CE]) begin
        data_shadow_q <= lcd_data_in;
        cd_shadow_q   <= s[CTRL_CD];
      end
      push_q   <= push_d;
      rd_evt_q <= rd_evt_d;
      oe_q     <= oe_d;
    end
  end

  lcd_resp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push_q),
    .wdata_i ({cd_shadow_q, data_shadow_q}),
    .pop_i   (cmd_ready),
    .head_o  (head),
    .valid_o (cmd_valid),
    .full_o  (fifo_full)
  );

  assign drop = push_q & fifo_full & !(cmd_ready & cmd_valid);

  always_comb begin
    dout_d = dout_q;
`ifdef LCD_RESP_STATUS_EN
    fresh_d = fresh_q;
    if (rd_evt_q) begin
      if (rd_cd_q) begin
        dout_d = status_byte(!fifo_full, !cmd_valid, ovf_q, fresh_q);
      end else begin
        dout_d  = rb_q;
        fresh_d = 1'b0;
      end
    end
    if (rdata_load) begin
      fresh_d = 1'b1;
    end
    ovf_d = drop | (ovf_q & !ovf_clr_q);
`else
    if (rd_evt_q) begin
      dout_d = rb_q;
    end
    ovf_d = drop | ovf_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
      rb_q   <= '0;
      ovf_q  <= 1'b0;
`ifdef LCD_RESP_STATUS_EN
      rd_cd_q   <= 1'b0;
      fresh_q   <= 1'b0;
      ovf_clr_q <= 1'b0;
`endif
    end else begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      if (rdata_load) begin
        rb_q <= rdata_value;
      end
`ifdef LCD_RESP_STATUS_EN
      if (rd_evt_d) begin
        rd_cd_q <= s[CTRL_CD];
      end
      fresh_q   <= fresh_d;
      ovf_clr_q <= rd_evt_q & rd_cd_q;
`endif
    end
  end

  assign lcd_data_out = dout_q;
  assign lcd_data_oe  = oe_q;
  assign cmd_cd       = head.cd;
  assign cmd_data     = head.data;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed self-checking bench for lcd_bus_responder (FIFO_DEPTH=8, SYNC_STAGES=2).
module tb_lcd_bus_responder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ctrl = 4'b0111;
  logic [7:0] din = '0;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic       cmd_valid, cmd_cd;
  logic [7:0] cmd_data;
  logic       cmd_ready = 1'b0;
  logic       rdata_load = 1'b0;
  logic [7:0] rdata_value = '0;
  logic       overflow;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned valid_cycles = 0;
  int unsigned oe_cycles = 0;
  logic [8:0]  popped [$];

  always #5 clk = ~clk;

  lcd_bus_responder #(
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .csi_clockreset_clk    (clk),
    .csi_clockreset_reset_n(rst_n),
    .lcd_ctrl_in           (ctrl),
    .lcd_data_in           (din),
    .lcd_data_out          (lcd_data_out),
    .lcd_data_oe           (lcd_data_oe),
    .cmd_valid             (cmd_valid),
    .cmd_cd                (cmd_cd),
    .cmd_data              (cmd_data),
    .cmd_ready             (cmd_ready),
    .rdata_load            (rdata_load),
    .rdata_value           (rdata_value),
    .overflow              (overflow)
  );

  always @(negedge clk) begin
    if (cmd_valid) valid_cycles++;
    if (lcd_data_oe) oe_cycles++;
    if (cmd_valid && cmd_ready && rst_n) popped.push_back({cmd_cd, cmd_data});
  end

  function automatic logic [3:0] mk(input logic ce, input logic iorn,
                                    input logic iown, input logic cd);
    return {cd, iown, iorn, ce};
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_write(input logic cd, input logic [7:0] d, input bit pop_at_push);
    ctrl = mk(1'b0, 1'b1, 1'b0, cd);
    din  = d;
    cyc(5);
    ctrl = mk(1'b0, 1'b1, 1'b1, cd);
    cyc(1);
    ctrl = mk(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1);
    if (pop_at_push) begin
      cyc(1);
      cmd_ready = 1'b1;
      cyc(1);
      cmd_ready = 1'b0;
      cyc(3);
    end else begin
      cyc(5);
    end
  endtask

  task automatic bus_read(input logic cd, output logic [7:0] d);
    oe_cycles = 0;
    ctrl = mk(1'b0, 1'b0, 1'b1, cd);
    cyc(6);
    d = lcd_data_out;
    ctrl = mk(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    tests++; if (lcd_data_out !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", lcd_data_out); end
    tests++; if (lcd_data_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b expected 0", lcd_data_oe); end
    tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
    tests++; if ({cmd_cd, cmd_data} !== 9'h000) begin fails++; $display("FAIL reset_head: got %h expected 000", {cmd_cd, cmd_data}); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    rst_n = 1'b1;
    cyc(4);
  endtask

  task automatic test_write_pop();
    logic [8:0] exp [3];
    exp[0] = 9'h140; exp[1] = 9'h0A5; exp[2] = 9'h05A;
    popped.delete();
    cmd_ready = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 3; i++) bus_write(exp[i][8], exp[i][7:0], 1'b0);
    cyc(3);
    cmd_ready = 1'b0;
    tests++; if (popped.size() !== 3) begin fails++; $display("FAIL wr_count: got %0d expected 3", popped.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (popped[i] !== exp[i]) begin fails++; $display("FAIL wr_entry%0d: got %h expected %h", i, popped[i], exp[i]); end
    end
    tests++; if (valid_cycles !== 3) begin fails++; $display("FAIL wr_valid_cycles: got %0d expected 3", valid_cycles); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL wr_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] rd;
    logic [7:0] exp_st1, exp_st2;
    logic       exp_ovf;
`ifdef LCD_RESP_STATUS_EN
    exp_st1 = 8'h04; exp_st2 = 8'h00; exp_ovf = 1'b0;
`else
    exp_st1 = 8'h00; exp_st2 = 8'h00; exp_ovf = 1'b1;
`endif
    popped.delete();
    cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(i[0], 8'(8'h10 + i), 1'b0);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    tests++; if ({cmd_valid, cmd_cd, cmd_data} !== 10'h210) begin fails++; $display("FAIL ovf_head: got %h expected 210", {cmd_valid, cmd_cd, cmd_data}); end
    bus_read(1'b1, rd);
    tests++; if (rd !== exp_st1) begin fails++; $display("FAIL ovf_status1: got %h expected %h", rd, exp_st1); end
    tests++; if (overflow !== exp_ovf) begin fails++; $display("FAIL ovf_after_read: got %b expected %b", overflow, exp_ovf); end
    bus_read(1'b1, rd);
    tests++; if (rd !== exp_st2) begin fails++; $display("FAIL ovf_status2: got %h expected %h", rd, exp_st2); end
    cmd_ready = 1'b1;
    cyc(12);
    cmd_ready = 1'b0;
    tests++; if (popped.size() !== DEPTH) begin fails++; $display("FAIL ovf_drain_count: got %0d expected %0d", popped.size(), DEPTH); end
    for (int i = 0; i < int'(DEPTH); i++) begin
      tests++; if (popped[i] !== {i[0], 8'(8'h10 + i)}) begin fails++; $display("FAIL ovf_entry%0d: got %h expected %h", i, popped[i], {i[0], 8'(8'h10 + i)}); end
    end
  endtask

  task automatic test_readback();
    logic [7:0] rd;
    logic [7:0] exp_st1, exp_st2;
`ifdef LCD_RESP_STATUS_EN
    exp_st1 = 8'h0B; exp_st2 = 8'h03;
`else
    exp_st1 = 8'hC3; exp_st2 = 8'hC3;
`endif
    rdata_value = 8'hC3;
    rdata_load  = 1'b1;
    cyc(1);
    rdata_load  = 1'b0;
    rdata_value = 8'h00;
    cyc(1);
    bus_read(1'b1, rd);
    tests++; if (rd !== exp_st1) begin fails++; $display("FAIL rb_status_fresh: got %h expected %h", rd, exp_st1); end
    bus_read(1'b0, rd);
    tests++; if (rd !== 8'hC3) begin fails++; $display("FAIL rb_data: got %h expected c3", rd); end
    tests++; if (oe_cycles !== 6) begin fails++; $display("FAIL rb_oe_cycles: got %0d expected 6", oe_cycles); end
    bus_read(1'b1, rd);
    tests++; if (rd !== exp_st2) begin fails++; $display("FAIL rb_status_cleared: got %h expected %h", rd, exp_st2); end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    popped.delete();
    cmd_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) bus_write(i[1], 8'(8'h80 + i), 1'b0);
    tests++; if ({cmd_valid, overflow} !== 2'b10) begin fails++; $display("FAIL b2b_full: got %b expected 10", {cmd_valid, overflow}); end
    bus_write(1'b1, 8'h99, 1'b1);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_no_ovf: got %b expected 0", overflow); end
    tests++; if ({cmd_cd, cmd_data} !== 9'h081) begin fails++; $display("FAIL b2b_head: got %h expected 081", {cmd_cd, cmd_data}); end
    bus_write(1'b0, 8'hEE, 1'b0);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL b2b_still_full: got %b expected 1", overflow); end
    cmd_ready = 1'b1;
    cyc(12);
    cmd_ready = 1'b0;
    tests++; if (popped.size() !== DEPTH + 1) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", popped.size(), DEPTH + 1); end
    for (int i = 0; i < int'(DEPTH); i++) begin
      tests++; if (popped[i] !== {i[1], 8'(8'h80 + i)}) begin fails++; $display("FAIL b2b_entry%0d: got %h expected %h", i, popped[i], {i[1], 8'(8'h80 + i)}); end
    end
    tests++; if (popped[DEPTH] !== 9'h199) begin fails++; $display("FAIL b2b_tail: got %h expected 199", popped[DEPTH]); end
  endtask

  task automatic test_bus_error();
    logic [7:0] dout_before;
    dout_before = lcd_data_out;
    oe_cycles = 0;
    ctrl = mk(1'b0, 1'b0, 1'b0, 1'b1);
    din  = 8'h77;
    cyc(6);
    ctrl = mk(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(6);
    tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL err_no_push: got %b expected 0", cmd_valid); end
    tests++; if (oe_cycles !== 0) begin fails++; $display("FAIL err_no_oe: got %0d expected 0", oe_cycles); end
    tests++; if (lcd_data_out !== dout_before) begin fails++; $display("FAIL err_no_load: got %h expected %h", lcd_data_out, dout_before); end
    ctrl = mk(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(5);
    ctrl = mk(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(3);
    ctrl = mk(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(6);
    tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL ce_release_no_push: got %b expected 0", cmd_valid); end
  endtask

  task automatic test_reset_mid_strobe();
    logic [7:0] rd;
    cmd_ready = 1'b0;
    bus_write(1'b1, 8'h3C, 1'b0);
    rdata_value = 8'h5A;
    rdata_load  = 1'b1;
    cyc(1);
    rdata_load  = 1'b0;
    bus_read(1'b0, rd);
    tests++; if ({cmd_valid, rd} !== 9'h15A) begin fails++; $display("FAIL mid_pre: got %h expected 15a", {cmd_valid, rd}); end
    ctrl = mk(1'b0, 1'b1, 1'b0, 1'b0);
    din  = 8'hAA;
    cyc(4);
    rst_n = 1'b0;
    cyc(1);
    tests++; if ({lcd_data_oe, lcd_data_out} !== 9'h000) begin fails++; $display("FAIL mid_rst_out: got %h expected 000", {lcd_data_oe, lcd_data_out}); end
    tests++; if ({cmd_valid, cmd_cd, cmd_data, overflow} !== 11'h000) begin fails++; $display("FAIL mid_rst_fifo: got %h expected 000", {cmd_valid, cmd_cd, cmd_data, overflow}); end
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    ctrl = mk(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1);
    ctrl = mk(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(6);
    tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL mid_no_push: got %b expected 0", cmd_valid); end
    bus_write(1'b0, 8'h42, 1'b0);
    tests++; if ({cmd_valid, cmd_cd, cmd_data} !== 10'h242) begin fails++; $display("FAIL mid_recover: got %h expected 242", {cmd_valid, cmd_cd, cmd_data}); end
  endtask

  initial begin
    test_reset();
    test_write_pop();
    test_overflow();
    test_readback();
    test_back_to_back();
    test_bus_error();
    test_reset_mid_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Target-side endpoint of the 8-bit 8080-style LCD bus (CE, IORn, IOWn, CD, active-low strobes) that the Avalon LCD bridge drives. It samples the asynchronous bus strobes in the system clock domain, queues every write cycle as a {CD, data} entry in a small FIFO for a downstream consumer (LCD emulator, bus monitor, loopback bench), and answers read cycles with a status byte (CD=1) or a host-loaded readback byte (CD=0). It sits at the FPGA pins or bench boundary, opposite the bridge.

## Interface
- FIFO_DEPTH, 8: write-entry FIFO depth; power of two, 2..64.
- SYNC_STAGES, 2: strobe synchronizer flops, 2..3.

- csi_clockreset_clk  in  1  system clock; all logic on rising edge.
- csi_clockreset_reset_n  in  1  synchronous, active-low reset.
- lcd_ctrl_in  in  4  bit0 CE, bit1 IORn, bit2 IOWn, bit3 CD; all active-low except CD (1 = command/status, 0 = data).
- lcd_data_in  in  8  bus data from initiator (LCD_DATA[7:0]).
- lcd_data_out  out  8  read response byte.
- lcd_data_oe  out  1  1 = drive lcd_data_out onto the bus.
- cmd_valid  out  1  FIFO head valid.
- cmd_cd  out  1  CD of the head entry.
- cmd_data  out  8  data of the head entry.
- cmd_ready  in  1  consumer pops head when cmd_valid & cmd_ready.
- rdata_load  in  1  load rdata_value into readback register.
- rdata_value  in  8  readback byte for CD=0 reads.
- overflow  out  1  sticky: a write arrived while FIFO full.

## Operation
- Strobes CE, IORn, IOWn, CD pass through SYNC_STAGES flops (reset value 1,1,1,0); edge detection compares last synchronized stage with one further delay flop.
- lcd_data_in is registered every cycle while synchronized IOWn=0 & CE=0 (shadow byte); CD is latched alongside.
- Write cycle: rising edge of synchronized IOWn with CE=0 one cycle earlier → push {cd_shadow, data_shadow}. FIFO full → entry dropped, overflow set.
- Read cycle: falling edge of synchronized IORn with CE=0 → load lcd_data_out: CD=1 → status byte; CD=0 → readback register. lcd_data_oe = synchronized (CE=0 & IORn=0), registered.
- Status byte: bit0 FIFO not full, bit1 FIFO empty, bit2 overflow, bit3 readback fresh (set by rdata_load, cleared by a CD=0 read), bits7:4 = 0.
- overflow clears on the cycle after a CD=1 read is loaded; a new overflow in the same cycle wins (stays set).
- Simultaneous push and pop: both happen; with FIFO full, pop occurs first, so the push succeeds.
- IOWn and IORn both low: treated as bus error; neither push nor response load, oe stays 0.
- CE released mid-strobe: no push/no load on the later strobe edge.

## Timing
- Reset: lcd_data_out=0, lcd_data_oe=0, cmd_valid=0, cmd_cd=0, cmd_data=0, overflow=0, FIFO empty, readback register 0, fresh=0.
- Initiator strobe pulse ≥ SYNC_STAGES+2 clocks; setup of data/CD to strobe release ≥ SYNC_STAGES+1 clocks.
- IOWn rise sampled at edge N → push at edge N+SYNC_STAGES+1; cmd_valid high after that edge when FIFO was empty.
- IORn fall sampled at edge N → lcd_data_out valid and lcd_data_oe high after edge N+SYNC_STAGES+1; oe drops SYNC_STAGES+1 clocks after IORn rise.
- cmd_* registered FIFO outputs; pop takes effect on the handshake edge, next entry visible the following cycle (no bubble).

## Configuration
- LCD_RESP_STATUS_EN defined: CD=1 reads return the status byte; overflow clear-on-read active.
- Undefined: CD=1 reads return the readback register (same as CD=0, fresh flag unaffected); overflow sticky until reset; status logic removed.

## Structure
- Shared package lcd_bus_pkg: control bit index constants (CE=0, IORn=1, IOWn=2, CD=3), status bit indices, entry type {cd, data[7:0]}.
- One sub-module: lcd_resp_fifo (synchronous FIFO, registered head, full/empty, simultaneous push/pop).

## Test plan
- Reset then 3 writes (CD=1 8'h40, CD=0 8'hA5, CD=0 8'h5A), cmd_ready=1 → entries pop in order, cmd_valid high 3 cycles total, overflow=0.
- cmd_ready=0, FIFO_DEPTH+1 writes → first 8 retained, 9th dropped, overflow=1; status read returns 8'h04|bit0=0 (8'h04), next status read 8'h00 (with STATUS_EN).
- rdata_load with 8'hC3, CD=0 read → lcd_data_out=8'hC3, oe high for strobe duration+latency; following status read bit3=0.
- Full FIFO, pop and write-edge in same cycle → no overflow, FIFO stays full, new entry at tail.
- IOWn and IORn both low for 6 clocks → no push, lcd_data_oe stays 0.
- Reset asserted mid-write strobe → outputs return to reset values next edge; strobe rise after reset release pushes nothing.
